// File: rtl/execute_mdu_pkg.sv
// execute_mdu shared definitions
// states, operand sizes, EFLAGS bits, MDU opcodes
package execute_mdu_pkg;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    typedef enum logic [1:0] {
        SZ_8   = 2'd0,
        SZ_16  = 2'd1,
        SZ_32  = 2'd2,
        SZ_RSV = 2'd3
    } opnd_size_t;

    localparam int EFLAGS_CF = 0;
    localparam int EFLAGS_PF = 2;
    localparam int EFLAGS_AF = 4;
    localparam int EFLAGS_ZF = 6;
    localparam int EFLAGS_SF = 7;
    localparam int EFLAGS_OF = 11;

    localparam logic [5:0] CMD_MUL  = 6'h1c;
    localparam logic [5:0] CMD_IMUL = 6'h1d;
    localparam logic [5:0] CMD_DIV  = 6'h1e;
    localparam logic [5:0] CMD_IDIV = 6'h1f;

    // reserved size code behaves like the widest size
    function automatic int unsigned size_bits(
        input logic [1:0]  sz,
        input int unsigned width
    );
        int unsigned n;
        case (sz)
            SZ_8:    n = 8;
            SZ_16:   n = 16;
            default: n = width;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/execute_mdu_step.sv
// execute_mdu single radix-2 iteration
// shift-add multiply or restoring-divide step
module execute_mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] sh,
    input  logic [WIDTH-1:0]   qr,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic [2*WIDTH-1:0] sh_nxt,
    output logic [WIDTH-1:0]   qr_nxt
);

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   dvsr;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // one iteration: div brings in the next dividend bit, mul adds a partial product
    always_comb begin
        trial = {acc[WIDTH-1:0], qr[WIDTH-1]};
        dvsr  = {1'b0, sh[WIDTH-1:0]};
        ge    = trial >= dvsr;
        diff  = WIDTH'(trial - dvsr);
        if (is_div) begin
            acc_nxt = {{WIDTH{1'b0}}, ge ? diff : trial[WIDTH-1:0]};
            sh_nxt  = sh;
            qr_nxt  = {qr[WIDTH-2:0], ge};
        end else begin
            acc_nxt = qr[0] ? acc + sh : acc;
            sh_nxt  = sh << 1;
            qr_nxt  = qr >> 1;
        end
    end

endmodule

// File: rtl/execute_mdu.sv
// execute_mdu multi-cycle multiply/divide unit
// MUL/IMUL/DIV/IDIV on 8/16/32-bit operands
module execute_mdu
    import execute_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opc,
    input  logic [1:0]       opnd_size,
    input  logic [31:0]      eflags,
    input  logic [WIDTH-1:0] opnd0_r,
    input  logic [WIDTH-1:0] opnd1_r,
    input  logic [WIDTH-1:0] opnd2_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] opnd0_w,
    output logic [WIDTH-1:0] opnd1_w,
    output logic [31:0]      o_eflags,
    output logic             fault_de
);

    localparam int W2 = 2 * WIDTH;

    mdu_state_t state_q, state_d;
    logic       accept;

    logic [CNT_W-1:0] cnt_q, n_q, n_in;
    logic [5:0]       opc_q;
    logic [31:0]      efl_q;
    logic [W2-1:0]    acc_q, sh_q, acc_s, sh_s;
    logic [WIDTH-1:0] qr_q, qr_s;
    logic             neg_res_q, neg_rem_q, big_q;
    logic             is_mul_q;

    int unsigned      nw_in;
    logic             is_mul_in, is_div_in, sgn_in, early;
    logic             a_neg, b_neg, h_neg;
    logic [WIDTH-1:0] mask_in, sbit_in, a_t, b_t, h_t;
    logic [WIDTH-1:0] a_mag, b_mag, dh_mag, dl_mag;
    logic [W2-1:0]    dvd, dvd_mag, mask2_in;

    int unsigned      nw_q;
    logic [WIDTH-1:0] mask_q, half_q, p_lo, p_hi, sx;
    logic [WIDTH-1:0] q_mag, r_mag;
    logic [W2-1:0]    mask2_q, prod;
    logic             cfo, ovf;
    logic [WIDTH-1:0] fx_q, fx_r;
    logic [31:0]      fx_fl;
    logic             fx_fault;

    assign out_valid = (state_q == MDU_DONE);
    assign is_mul_q  = (opc_q == CMD_MUL) | (opc_q == CMD_IMUL);

    // request decode: truncate, sign-extend and take magnitudes at the selected size
    always_comb begin
        nw_in     = size_bits(opnd_size, WIDTH);
        n_in      = CNT_W'(nw_in);
        is_mul_in = (opc == CMD_MUL) | (opc == CMD_IMUL);
        is_div_in = (opc == CMD_DIV) | (opc == CMD_IDIV);
        sgn_in    = (opc == CMD_IMUL) | (opc == CMD_IDIV);
        mask_in   = {WIDTH{1'b1}} >> (WIDTH - nw_in);
        sbit_in   = WIDTH'(1) << (nw_in - 1);
        a_t       = opnd0_r & mask_in;
        b_t       = opnd1_r & mask_in;
        h_t       = opnd2_r & mask_in;
        a_neg     = sgn_in & (|(a_t & sbit_in));
        b_neg     = sgn_in & (|(b_t & sbit_in));
        h_neg     = sgn_in & (|(h_t & sbit_in));
        a_mag     = a_neg ? (~a_t + WIDTH'(1)) & mask_in : a_t;
        b_mag     = b_neg ? (~b_t + WIDTH'(1)) & mask_in : b_t;
        dvd       = (W2'(h_t) << nw_in) | W2'(a_t);
        mask2_in  = (W2'(1) << (2 * nw_in)) - W2'(1);
        dvd_mag   = h_neg ? (~dvd + W2'(1)) & mask2_in : dvd;
        dh_mag    = WIDTH'(dvd_mag >> nw_in);
        dl_mag    = dvd_mag[WIDTH-1:0] & mask_in;
        early     = (is_div_in & ((b_t == '0) |
                    ((opc == CMD_DIV) & (h_t >= b_t)))) |
                    ~(is_mul_in | is_div_in);
    end

    // handshake and next state
    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == MDU_IDLE) |
                   ((state_q == MDU_DONE) & out_ready);
        accept   = in_valid & in_ready;
        unique case (state_q)
            MDU_IDLE: begin
                if (accept) state_d = early ? MDU_DONE : MDU_CALC;
            end
            MDU_CALC: begin
                if (cnt_q == CNT_W'(1)) state_d = MDU_DONE;
            end
            MDU_DONE: begin
                if (accept) state_d = early ? MDU_DONE : MDU_CALC;
                else if (out_ready) state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= MDU_IDLE;
        else     state_q <= state_d;
    end

    execute_mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div  (~is_mul_q),
        .acc     (acc_q),
        .sh      (sh_q),
        .qr      (qr_q),
        .acc_nxt (acc_s),
        .sh_nxt  (sh_s),
        .qr_nxt  (qr_s)
    );

    // sign fixup, flags and overflow on the last iteration's result
    always_comb begin
        nw_q     = 32'(n_q);
        mask_q   = {WIDTH{1'b1}} >> (WIDTH - nw_q);
        half_q   = WIDTH'(1) << (nw_q - 1);
        mask2_q  = (W2'(1) << (2 * nw_q)) - W2'(1);
        prod     = neg_res_q ? (~acc_s + W2'(1)) & mask2_q : acc_s;
        p_lo     = prod[WIDTH-1:0] & mask_q;
        p_hi     = WIDTH'(prod >> nw_q) & mask_q;
        sx       = (|(p_lo & half_q)) ? mask_q : '0;
        cfo      = (opc_q == CMD_IMUL) ? (p_hi != sx) : (p_hi != '0);
        q_mag    = qr_s & mask_q;
        r_mag    = acc_s[WIDTH-1:0];
        ovf      = (opc_q == CMD_IDIV) & (big_q |
                   (neg_res_q ? (q_mag > half_q) : (q_mag >= half_q)));
        fx_q     = '0;
        fx_r     = '0;
        fx_fl    = efl_q;
        fx_fault = 1'b0;
        unique case (1'b1)
            is_mul_q: begin
                fx_q             = p_lo;
                fx_r             = p_hi;
                fx_fl[EFLAGS_CF] = cfo;
                fx_fl[EFLAGS_OF] = cfo;
            end
            ovf: begin
                fx_fault = 1'b1;
            end
            default: begin
                fx_q = neg_res_q ? (~q_mag + WIDTH'(1)) & mask_q : q_mag;
                fx_r = neg_rem_q ? (~r_mag + WIDTH'(1)) & mask_q : r_mag;
            end
        endcase
    end

    // operand latch, iteration registers and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            n_q       <= '0;
            opc_q     <= '0;
            efl_q     <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            qr_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            big_q     <= 1'b0;
            opnd0_w   <= '0;
            opnd1_w   <= '0;
            o_eflags  <= '0;
            fault_de  <= 1'b0;
        end else if (accept) begin
            opc_q     <= opc;
            n_q       <= n_in;
            cnt_q     <= n_in;
            efl_q     <= eflags;
            neg_rem_q <= h_neg;
            big_q     <= dh_mag >= b_mag;
            if (is_mul_in) begin
                neg_res_q <= a_neg ^ b_neg;
                acc_q     <= '0;
                sh_q      <= W2'(a_mag);
                qr_q      <= b_mag;
            end else begin
                neg_res_q <= h_neg ^ b_neg;
                acc_q     <= W2'(dh_mag);
                sh_q      <= W2'(b_mag);
                qr_q      <= dl_mag << (WIDTH - nw_in);
            end
            if (early) begin
                opnd0_w  <= is_div_in ? '0 : opnd0_r;
                opnd1_w  <= '0;
                o_eflags <= eflags;
                fault_de <= is_div_in;
            end
        end else if (state_q == MDU_CALC) begin
            acc_q <= acc_s;
            sh_q  <= sh_s;
            qr_q  <= qr_s;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                opnd0_w  <= fx_q;
                opnd1_w  <= fx_r;
                o_eflags <= fx_fl;
                fault_de <= fx_fault;
            end
        end
    end

endmodule

// File: tb/tb_execute_mdu.sv
// execute_mdu testbench
// directed and random ops against an arithmetic reference
module tb_execute_mdu;
    import execute_mdu_pkg::*;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] fl;
        logic        f;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opc;
    logic [1:0]  opnd_size;
    logic [31:0] eflags;
    logic [31:0] opnd0_r, opnd1_r, opnd2_r;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] opnd0_w, opnd1_w, o_eflags;
    logic        fault_de;

    int checks = 0;
    int errors = 0;

    execute_mdu #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opc       (opc),
        .opnd_size (opnd_size),
        .eflags    (eflags),
        .opnd0_r   (opnd0_r),
        .opnd1_r   (opnd1_r),
        .opnd2_r   (opnd2_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opnd0_w   (opnd0_w),
        .opnd1_w   (opnd1_w),
        .o_eflags  (o_eflags),
        .fault_de  (fault_de)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sext(input logic [63:0] v, input int n);
        logic [63:0] t;
        t = v << (64 - n);
        return $signed(t) >>> (64 - n);
    endfunction

    function automatic exp_t model(input logic [5:0] op,
                                   input logic [1:0] sz,
                                   input logic [31:0] fl,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [31:0] h);
        exp_t e;
        int n;
        logic [63:0] m, ua, ub, uh, p, dvd, uq;
        longint sa, sb, sp, sd, sq, sr, lim;
        logic cf, flt;
        n = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
        m = (64'd1 << n) - 64'd1;
        ua = {32'd0, a} & m;
        ub = {32'd0, b} & m;
        uh = {32'd0, h} & m;
        sa = sext(ua, n);
        sb = sext(ub, n);
        lim = longint'(64'd1 << (n - 1));
        e.q = '0; e.r = '0; e.fl = fl; e.f = 1'b0; e.lat = n + 1;
        flt = 1'b0;
        sq = 0; sr = 0;
        case (op)
            CMD_MUL: begin
                p = ua * ub;
                e.q = 32'(p & m);
                e.r = 32'((p >> n) & m);
                cf = (e.r != 0);
                e.fl[EFLAGS_CF] = cf;
                e.fl[EFLAGS_OF] = cf;
            end
            CMD_IMUL: begin
                sp = sa * sb;
                e.q = 32'(sp & m);
                e.r = 32'((sp >>> n) & m);
                cf = (sp >= lim) || (sp < -lim);
                e.fl[EFLAGS_CF] = cf;
                e.fl[EFLAGS_OF] = cf;
            end
            CMD_DIV: begin
                dvd = (uh << n) | ua;
                if (ub == 0) begin
                    flt = 1'b1; e.lat = 1;
                end else begin
                    uq = dvd / ub;
                    if (uq > m) begin
                        flt = 1'b1; e.lat = 1;
                    end else begin
                        e.q = 32'(uq);
                        e.r = 32'(dvd % ub);
                    end
                end
            end
            CMD_IDIV: begin
                sd = sext((uh << n) | ua, 2 * n);
                if (sb == 0) begin
                    flt = 1'b1; e.lat = 1;
                end else if (sb == -1) begin
                    flt = (sd > lim) || (sd < -(lim - 1));
                    if (!flt) sq = -sd;
                end else begin
                    sq = sd / sb;
                    sr = sd % sb;
                    flt = (sq >= lim) || (sq < -lim);
                end
                if (!flt) begin
                    e.q = 32'(sq & m);
                    e.r = 32'(sr & m);
                end
            end
            default: begin
                e.q = a;
                e.lat = 1;
            end
        endcase
        if (flt) begin
            e.f = 1'b1; e.q = '0; e.r = '0; e.fl = fl;
        end
        return e;
    endfunction

    task automatic run_op(input logic [5:0] op, input logic [1:0] sz,
                          input logic [31:0] fl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] h,
                          input int hold, input string tag);
        exp_t e;
        int lat;
        logic got;
        e = model(op, sz, fl, a, b, h);
        opc = op; opnd_size = sz; eflags = fl;
        opnd0_r = a; opnd1_r = b; opnd2_r = h;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, 64'(in_ready), 64'(1));
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            out_ready = (hold == 0);
            lat++;
            got = out_valid;
        end
        check({tag, "_lat"}, 64'(lat), 64'(e.lat));
        check({tag, "_q"}, 64'(opnd0_w), 64'(e.q));
        check({tag, "_r"}, 64'(opnd1_w), 64'(e.r));
        check({tag, "_fl"}, 64'(o_eflags), 64'(e.fl));
        check({tag, "_de"}, 64'(fault_de), 64'(e.f));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hv"}, 64'(out_valid), 64'(1));
            check({tag, "_hr"}, 64'(in_ready), 64'(0));
            check({tag, "_hq"}, 64'(opnd0_w), 64'(e.q));
            check({tag, "_hh"}, 64'(opnd1_w), 64'(e.r));
        end
    endtask

    initial begin
        logic [5:0]  rop;
        logic [1:0]  rsz;
        logic [31:0] ra, rb, rh, rm;
        int          stale;
        int          sel;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        opc = '0; opnd_size = '0; eflags = '0;
        opnd0_r = '0; opnd1_r = '0; opnd2_r = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_de", 64'(fault_de), 64'(0));
        check("rst_q", 64'(opnd0_w), 64'(0));
        check("rst_r", 64'(opnd1_w), 64'(0));
        check("rst_fl", 64'(o_eflags), 64'(0));
        rst = 1'b0;
        #1;
        check("rst_rdy", 64'(in_ready), 64'(1));

        run_op(CMD_MUL, 2'd2, 32'h0000_00d4, 32'hffff_ffff,
               32'd2, 32'd0, 0, "mul32");
        run_op(CMD_IMUL, 2'd0, 32'h0000_0803, 32'h0000_00fd,
               32'd5, 32'd0, 0, "imul8");
        run_op(CMD_DIV, 2'd2, 32'h0000_0044, 32'd100,
               32'd7, 32'd0, 0, "div32");
        run_op(CMD_IDIV, 2'd1, 32'h0000_0080, 32'h0000_fff9,
               32'd2, 32'h0000_ffff, 0, "idiv16");
        run_op(CMD_DIV, 2'd2, 32'h0000_0001, 32'd55,
               32'd0, 32'd0, 0, "div0");
        run_op(CMD_DIV, 2'd0, 32'h0000_0800, 32'h0000_0034,
               32'd8, 32'd8, 0, "div8ovf");
        run_op(CMD_IDIV, 2'd0, 32'h0000_0004, 32'h0000_0080,
               32'h0000_00ff, 32'h0000_00ff, 0, "idiv8ovf");
        run_op(6'h05, 2'd2, 32'h0000_0ac1, 32'h1234_5678,
               32'h9abc_def0, 32'h1111_1111, 0, "unsup");
        run_op(CMD_IMUL, 2'd1, 32'h0000_0000, 32'h0000_8000,
               32'h0000_8000, 32'd0, 5, "hold");
        run_op(CMD_MUL, 2'd3, 32'h0000_0000, 32'h8000_0001,
               32'h0000_0003, 32'd0, 0, "b2b");

        opc = CMD_MUL; opnd_size = 2'd2; eflags = 32'h0;
        opnd0_r = 32'hdead_beef; opnd1_r = 32'h1234_5678;
        opnd2_r = '0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rstc_acc", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstc_valid", 64'(out_valid), 64'(0));
        check("rstc_rdy", 64'(in_ready), 64'(1));
        check("rstc_q", 64'(opnd0_w), 64'(0));
        stale = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("rstc_stale", 64'(stale), 64'(0));

        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: rop = CMD_MUL;
                1: rop = CMD_IMUL;
                2: rop = CMD_DIV;
                3: rop = CMD_IDIV;
                default: rop = 6'h00;
            endcase
            rsz = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            rh = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 5));
            if ($urandom_range(0, 3) != 0) begin
                rm = (rsz == 2'd0) ? 32'h80 :
                     (rsz == 2'd1) ? 32'h8000 : 32'h8000_0000;
                if (rop == CMD_DIV) rh = '0;
                if (rop == CMD_IDIV) rh = ((ra & rm) != 0) ? '1 : '0;
            end
            run_op(rop, rsz, $urandom, ra, rb, rh,
                   ($urandom_range(0, 7) == 0) ? 2 : 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
